// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the control sequencer: sequencer state encoding,
// opcode-class encoding, opcode constants, ALU operation constants, and the
// small decode helpers used by control_sequencer.
// -----------------------------------------------------------------------------
package cu_pkg;

   // Sequencer states. T0..T2 are instruction fetch and T3..T7 execute.
   typedef enum logic [3:0] {
      S_RST,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6,
      S_T7,
      S_HALT
   } state_t;

   // Instructions that share an execute sequence are grouped into one class.
   typedef enum logic [3:0] {
      C_LD,
      C_LDI,
      C_ST,
      C_ALU,
      C_IMM,
      C_MULDIV,
      C_UNARY,
      C_MFHI,
      C_MFLO,
      C_NOP,
      C_HALT,
      C_ILLEGAL
   } op_class_t;

   // Opcodes (ir[31:27]).
   localparam logic [4:0] OP_LD       = 5'h00;
   localparam logic [4:0] OP_LDI      = 5'h01;
   localparam logic [4:0] OP_ST       = 5'h02;
   localparam logic [4:0] OP_ALU_FIRST = 5'h03;
   localparam logic [4:0] OP_ALU_LAST  = 5'h0B;
   localparam logic [4:0] OP_ADDI     = 5'h0C;
   localparam logic [4:0] OP_ANDI     = 5'h0D;
   localparam logic [4:0] OP_ORI      = 5'h0E;
   localparam logic [4:0] OP_MUL      = 5'h0F;
   localparam logic [4:0] OP_DIV      = 5'h10;
   localparam logic [4:0] OP_NEG      = 5'h11;
   localparam logic [4:0] OP_NOT      = 5'h12;
   localparam logic [4:0] OP_MFHI     = 5'h18;
   localparam logic [4:0] OP_MFLO     = 5'h19;
   localparam logic [4:0] OP_NOP      = 5'h1A;
   localparam logic [4:0] OP_HALT     = 5'h1B;

   // ALU operation codes driven on alu_op.
   localparam logic [4:0] ALU_NONE    = 5'h00;
   localparam logic [4:0] ALU_ADD     = 5'h03;
   localparam logic [4:0] ALU_AND     = 5'h05;
   localparam logic [4:0] ALU_OR      = 5'h06;

   // Map an opcode to its execute class; unassigned opcodes are illegal.
   function automatic op_class_t classify(input logic [4:0] op);
      op_class_t c;
      case (op)
         OP_LD:                    c = C_LD;
         OP_LDI:                   c = C_LDI;
         OP_ST:                    c = C_ST;
         OP_ADDI, OP_ANDI, OP_ORI: c = C_IMM;
         OP_MUL, OP_DIV:           c = C_MULDIV;
         OP_NEG, OP_NOT:           c = C_UNARY;
         OP_MFHI:                  c = C_MFHI;
         OP_MFLO:                  c = C_MFLO;
         OP_NOP:                   c = C_NOP;
         OP_HALT:                  c = C_HALT;
         default:                  c = (op >= OP_ALU_FIRST && op <= OP_ALU_LAST) ? C_ALU : C_ILLEGAL;
      endcase
      return c;
   endfunction

   // Immediate forms reuse the ALU with the matching register-form operation.
   function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
      logic [4:0] a;
      case (op)
         OP_ANDI: a = ALU_AND;
         OP_ORI:  a = ALU_OR;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/reg_decoder.sv
// -----------------------------------------------------------------------------
// reg_decoder
// Converts a 4-bit register index plus enable into a 16-bit one-hot select.
// Ports:
//   idx    in  4   register index R0..R15
//   en     in  1   select enable; output is all-zero when low
//   onehot out 16  one-hot select, bit idx set when en=1
// -----------------------------------------------------------------------------
module reg_decoder (
   input  logic [3:0]  idx,
   input  logic        en,
   output logic [15:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit: fetches an instruction over T0..T2, then executes it
// over T3..T7 according to its opcode class. Strobes are Moore outputs decoded
// from the state register and ir; only mdr_in in a read-wait state follows
// mem_rdy directly. Status flags run/illegal/timeout are registered.
//
// Build option:
//   CU_MEM_TIMEOUT_EN  when defined, every memory wait state is bounded to 16
//                      cycles; on expiry the sequencer halts with timeout=1.
//                      When undefined, waits are unbounded and timeout=0.
//
// Ports:
//   clk        in   1   rising-edge clock
//   clr        in   1   synchronous active-high reset
//   ir         in  32   instruction: op=[31:27] ra=[26:23] rb=[22:19] rc=[18:15]
//   mem_rdy    in   1   memory read/write completion strobe
//   rin, rout  out 16   one-hot register load / bus-drive enables
//   pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out
//              out  1   bus-drive strobes (at most one per cycle)
//   pc_in, ir_in, mdr_in, mar_in, y_in, z_in, hi_in, lo_in, inc_pc
//              out  1   load strobes
//   read, write out 1   memory request strobes
//   alu_op     out  5   ALU operation, zero whenever z_in is low
//   run, illegal, timeout out 1 status flags
// -----------------------------------------------------------------------------
module control_sequencer
   import cu_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   input  logic        mem_rdy,
   output logic [15:0] rin,
   output logic [15:0] rout,
   output logic        pc_out,
   output logic        mdr_out,
   output logic        zhigh_out,
   output logic        zlow_out,
   output logic        hi_out,
   output logic        lo_out,
   output logic        c_out,
   output logic        pc_in,
   output logic        ir_in,
   output logic        mdr_in,
   output logic        mar_in,
   output logic        y_in,
   output logic        z_in,
   output logic        hi_in,
   output logic        lo_in,
   output logic        inc_pc,
   output logic        read,
   output logic        write,
   output logic [4:0]  alu_op,
   output logic        run,
   output logic        illegal,
   output logic        timeout
);

   state_t    state;
   op_class_t cls;
   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       rd_wait, wr_wait, tmo_hit;
   logic       rin_en, rout_en;
   logic [3:0] rin_idx, rout_idx;
   logic       unused_ir;

   assign op  = ir[31:27];
   assign ra  = ir[26:23];
   assign rb  = ir[22:19];
   assign rc  = ir[18:15];
   assign cls = classify(op);

   // Low instruction bits carry immediates for the datapath, not control.
   assign unused_ir = ^ir[14:0];

   // Memory wait states: fetch read, ld data read, st data write.
   assign rd_wait = (state == S_T1) || (state == S_T6 && cls == C_LD);
   assign wr_wait = (state == S_T7 && cls == C_ST);

`ifdef CU_MEM_TIMEOUT_EN
   logic       in_wait;
   logic [3:0] wait_cnt;

   assign in_wait = rd_wait || wr_wait;

   // The counter idles at zero outside wait states, so it is already clear on
   // entry to any wait; no two wait states are ever back to back.
   always_ff @(posedge clk) begin
      if (clr || !in_wait || mem_rdy) wait_cnt <= '0;
      else                            wait_cnt <= wait_cnt + 4'd1;
   end

   // Sixteenth consecutive wait cycle without completion.
   assign tmo_hit = in_wait && !mem_rdy && (wait_cnt == 4'hF);
`else
   assign tmo_hit = 1'b0;
`endif

   // Sequencer state and registered status flags.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (clr) begin
         state   <= S_RST;
         run     <= 1'b1;
         illegal <= 1'b0;
         timeout <= 1'b0;
      end else if (tmo_hit) begin
         state   <= S_HALT;
         run     <= 1'b0;
         timeout <= 1'b1;
      end else begin
         case (state)
            S_RST: state <= S_T0;
            S_T0:  state <= S_T1;
            S_T1:  if (mem_rdy) state <= S_T2;
            S_T2:  state <= S_T3;
            S_T3: begin
               case (cls)
                  C_MFHI, C_MFLO, C_NOP: state <= S_T0;
                  C_HALT: begin
                     state <= S_HALT;
                     run   <= 1'b0;
                  end
                  C_ILLEGAL: begin
                     state   <= S_HALT;
                     run     <= 1'b0;
                     illegal <= 1'b1;
                  end
                  default: state <= S_T4;
               endcase
            end
            S_T4:  state <= (cls == C_UNARY) ? S_T0 : S_T5;
            S_T5:  state <= (cls == C_LD || cls == C_ST || cls == C_MULDIV) ? S_T6 : S_T0;
            S_T6: begin
               if (cls == C_LD) begin
                  if (mem_rdy) state <= S_T7;
               end else if (cls == C_ST) begin
                  state <= S_T7;
               end else begin
                  state <= S_T0;
               end
            end
            S_T7:   if (cls != C_ST || mem_rdy) state <= S_T0;
            S_HALT: state <= S_HALT;
            default: state <= S_RST;
         endcase
      end
   end

   // Strobe decode from state and ir.
   // NOTE: every output gets a default at the top of this block; any path that
   // leaves a signal unassigned would otherwise infer a latch. Combinational
   // blocks use blocking (=) so later lines see the values set above them.
   always_comb begin
      rin_en    = 1'b0;
      rin_idx   = '0;
      rout_en   = 1'b0;
      rout_idx  = '0;
      pc_out    = 1'b0;
      mdr_out   = 1'b0;
      zhigh_out = 1'b0;
      zlow_out  = 1'b0;
      hi_out    = 1'b0;
      lo_out    = 1'b0;
      c_out     = 1'b0;
      pc_in     = 1'b0;
      ir_in     = 1'b0;
      mdr_in    = 1'b0;
      mar_in    = 1'b0;
      y_in      = 1'b0;
      z_in      = 1'b0;
      hi_in     = 1'b0;
      lo_in     = 1'b0;
      inc_pc    = 1'b0;
      read      = 1'b0;
      write     = 1'b0;
      alu_op    = ALU_NONE;

      case (state)
         S_T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
         end
         S_T1: begin
            read   = 1'b1;
            mdr_in = mem_rdy;
         end
         S_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         S_T3: begin
            case (cls)
               C_ALU, C_IMM, C_LDI, C_LD, C_ST: begin
                  rout_en  = 1'b1;
                  rout_idx = rb;
                  y_in     = 1'b1;
               end
               C_MULDIV: begin
                  rout_en  = 1'b1;
                  rout_idx = ra;
                  y_in     = 1'b1;
               end
               C_UNARY: begin
                  rout_en  = 1'b1;
                  rout_idx = rb;
                  alu_op   = op;
                  z_in     = 1'b1;
               end
               C_MFHI: begin
                  hi_out  = 1'b1;
                  rin_en  = 1'b1;
                  rin_idx = ra;
               end
               C_MFLO: begin
                  lo_out  = 1'b1;
                  rin_en  = 1'b1;
                  rin_idx = ra;
               end
               default: ;
            endcase
         end
         S_T4: begin
            case (cls)
               C_ALU, C_MULDIV: begin
                  rout_en  = 1'b1;
                  rout_idx = (cls == C_ALU) ? rc : rb;
                  alu_op   = op;
                  z_in     = 1'b1;
               end
               C_IMM: begin
                  c_out  = 1'b1;
                  alu_op = imm_alu_op(op);
                  z_in   = 1'b1;
               end
               C_LDI, C_LD, C_ST: begin
                  c_out  = 1'b1;
                  alu_op = ALU_ADD;
                  z_in   = 1'b1;
               end
               C_UNARY: begin
                  zlow_out = 1'b1;
                  rin_en   = 1'b1;
                  rin_idx  = ra;
               end
               default: ;
            endcase
         end
         S_T5: begin
            case (cls)
               C_ALU, C_IMM, C_LDI: begin
                  zlow_out = 1'b1;
                  rin_en   = 1'b1;
                  rin_idx  = ra;
               end
               C_LD, C_ST: begin
                  zlow_out = 1'b1;
                  mar_in   = 1'b1;
               end
               C_MULDIV: begin
                  zlow_out = 1'b1;
                  lo_in    = 1'b1;
               end
               default: ;
            endcase
         end
         S_T6: begin
            case (cls)
               C_LD: begin
                  read   = 1'b1;
                  mdr_in = mem_rdy;
               end
               C_ST: begin
                  rout_en  = 1'b1;
                  rout_idx = ra;
                  mdr_in   = 1'b1;
               end
               C_MULDIV: begin
                  zhigh_out = 1'b1;
                  hi_in     = 1'b1;
               end
               default: ;
            endcase
         end
         S_T7: begin
            case (cls)
               C_LD: begin
                  mdr_out = 1'b1;
                  rin_en  = 1'b1;
                  rin_idx = ra;
               end
               C_ST: write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   reg_decoder u_rin_dec (
      .idx    (rin_idx),
      .en     (rin_en),
      .onehot (rin)
   );

   reg_decoder u_rout_dec (
      .idx    (rout_idx),
      .en     (rout_en),
      .onehot (rout)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Self-checking bench for control_sequencer. A behavioural model expands each
// instruction into the list of per-cycle strobe patterns the instruction set
// defines; the bench drives random instructions and random memory latencies
// and compares every cycle against that list.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_control_sequencer;

   localparam int K_STEP = 0;
   localparam int K_RD   = 1;
   localparam int K_WR   = 2;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        mem_rdy = 1'b0;
   logic [31:0] ir = '0;
   logic [15:0] rin, rout;
   logic        pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out;
   logic        pc_in, ir_in, mdr_in, mar_in, y_in, z_in, hi_in, lo_in, inc_pc;
   logic        read, write;
   logic [4:0]  alu_op;
   logic        run, illegal, timeout;

   int checks   = 0;
   int failures = 0;
   int rd_seen  = 0;

   typedef struct packed {
      logic [15:0] rin;
      logic [15:0] rout;
      logic pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out;
      logic pc_in, ir_in, mdr_in, mar_in, y_in, z_in, hi_in, lo_in, inc_pc;
      logic read, write;
      logic [4:0] alu_op;
      logic run, illegal, timeout;
   } outs_t;

   typedef struct {
      outs_t o;
      int    kind;
   } step_t;

   step_t exp_q[$];

   logic [4:0] legal_ops [22] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                  5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F,
                                  5'h10, 5'h11, 5'h12, 5'h18, 5'h19, 5'h1A};
   logic [4:0] stop_ops  [10] = '{5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h1B, 5'h1C, 5'h1D,
                                  5'h1E, 5'h1F};

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk       (clk),
      .clr       (clr),
      .ir        (ir),
      .mem_rdy   (mem_rdy),
      .rin       (rin),
      .rout      (rout),
      .pc_out    (pc_out),
      .mdr_out   (mdr_out),
      .zhigh_out (zhigh_out),
      .zlow_out  (zlow_out),
      .hi_out    (hi_out),
      .lo_out    (lo_out),
      .c_out     (c_out),
      .pc_in     (pc_in),
      .ir_in     (ir_in),
      .mdr_in    (mdr_in),
      .mar_in    (mar_in),
      .y_in      (y_in),
      .z_in      (z_in),
      .hi_in     (hi_in),
      .lo_in     (lo_in),
      .inc_pc    (inc_pc),
      .read      (read),
      .write     (write),
      .alu_op    (alu_op),
      .run       (run),
      .illegal   (illegal),
      .timeout   (timeout)
   );

   // All strobes low, sequencer running, no error flags.
   function automatic outs_t idle();
      outs_t o;
      o = '0;
      o.run = 1'b1;
      return o;
   endfunction

   function automatic logic [15:0] oh(input logic [3:0] i);
      logic [15:0] one;
      one = 16'h0001;
      return one << i;
   endfunction

   function automatic outs_t sample();
      outs_t o;
      o.rin = rin;             o.rout = rout;
      o.pc_out = pc_out;       o.mdr_out = mdr_out;   o.zhigh_out = zhigh_out;
      o.zlow_out = zlow_out;   o.hi_out = hi_out;     o.lo_out = lo_out;
      o.c_out = c_out;         o.pc_in = pc_in;       o.ir_in = ir_in;
      o.mdr_in = mdr_in;       o.mar_in = mar_in;     o.y_in = y_in;
      o.z_in = z_in;           o.hi_in = hi_in;       o.lo_in = lo_in;
      o.inc_pc = inc_pc;       o.read = read;         o.write = write;
      o.alu_op = alu_op;       o.run = run;           o.illegal = illegal;
      o.timeout = timeout;
      return o;
   endfunction

   task automatic push(input outs_t o, input int kind);
      step_t s;
      s.o = o;
      s.kind = kind;
      exp_q.push_back(s);
   endtask

   // Reference model: the micro-step list of one instruction, fetch included.
   task automatic build_model(input logic [31:0] instr);
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      outs_t o;
      op = instr[31:27];
      ra = instr[26:23];
      rb = instr[22:19];
      rc = instr[18:15];
      exp_q.delete();
      o = idle(); o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; push(o, K_STEP);
      o = idle(); o.read = 1'b1; push(o, K_RD);
      o = idle(); o.mdr_out = 1'b1; o.ir_in = 1'b1; push(o, K_STEP);
      if (op >= 5'h03 && op <= 5'h0E) begin
         o = idle(); o.rout = oh(rb); o.y_in = 1'b1; push(o, K_STEP);
         o = idle(); o.z_in = 1'b1;
         if (op <= 5'h0B) begin
            o.rout = oh(rc);
            o.alu_op = op;
         end else begin
            o.c_out = 1'b1;
            o.alu_op = (op == 5'h0C) ? 5'h03 : (op == 5'h0D) ? 5'h05 : 5'h06;
         end
         push(o, K_STEP);
         o = idle(); o.zlow_out = 1'b1; o.rin = oh(ra); push(o, K_STEP);
      end else if (op <= 5'h02) begin
         o = idle(); o.rout = oh(rb); o.y_in = 1'b1; push(o, K_STEP);
         o = idle(); o.c_out = 1'b1; o.alu_op = 5'h03; o.z_in = 1'b1; push(o, K_STEP);
         if (op == 5'h01) begin
            o = idle(); o.zlow_out = 1'b1; o.rin = oh(ra); push(o, K_STEP);
         end else begin
            o = idle(); o.zlow_out = 1'b1; o.mar_in = 1'b1; push(o, K_STEP);
            if (op == 5'h00) begin
               o = idle(); o.read = 1'b1; push(o, K_RD);
               o = idle(); o.mdr_out = 1'b1; o.rin = oh(ra); push(o, K_STEP);
            end else begin
               o = idle(); o.rout = oh(ra); o.mdr_in = 1'b1; push(o, K_STEP);
               o = idle(); o.write = 1'b1; push(o, K_WR);
            end
         end
      end else if (op == 5'h0F || op == 5'h10) begin
         o = idle(); o.rout = oh(ra); o.y_in = 1'b1; push(o, K_STEP);
         o = idle(); o.rout = oh(rb); o.alu_op = op; o.z_in = 1'b1; push(o, K_STEP);
         o = idle(); o.zlow_out = 1'b1; o.lo_in = 1'b1; push(o, K_STEP);
         o = idle(); o.zhigh_out = 1'b1; o.hi_in = 1'b1; push(o, K_STEP);
      end else if (op == 5'h11 || op == 5'h12) begin
         o = idle(); o.rout = oh(rb); o.alu_op = op; o.z_in = 1'b1; push(o, K_STEP);
         o = idle(); o.zlow_out = 1'b1; o.rin = oh(ra); push(o, K_STEP);
      end else if (op == 5'h18) begin
         o = idle(); o.hi_out = 1'b1; o.rin = oh(ra); push(o, K_STEP);
      end else if (op == 5'h19) begin
         o = idle(); o.lo_out = 1'b1; o.rin = oh(ra); push(o, K_STEP);
      end else begin
         // nop, halt and illegal opcodes all spend one quiet decode cycle.
         push(idle(), K_STEP);
      end
   endtask

   // Drive one instruction through the DUT and compare every cycle.
   // fdly/xdly: mem_rdy delay for the fetch wait and the execute wait (<0: random).
   task automatic run_instr(input logic [31:0] instr, input int fdly, input int xdly,
                            input bit const_rdy, input string tag);
      step_t s;
      outs_t e, a;
      int d;
      int nwait;
      int n;
      nwait = 0;
      n = 0;
      build_model(instr);
      while (exp_q.size() > 0) begin
         s = exp_q.pop_front();
         if (s.kind == K_STEP) begin
            @(posedge clk); #1;
            ir = instr;
            mem_rdy = const_rdy ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            a = sample();
            checks++;
            if (a !== s.o) begin
               failures++;
               $display("FAIL %s op=%h cycle %0d: got %h expected %h", tag, instr[31:27], n, a, s.o);
            end
            n++;
         end else begin
            d = (nwait == 0) ? fdly : xdly;
            if (d < 0) d = int'($urandom_range(0, 4));
            nwait++;
            rd_seen = 0;
            for (int k = 0; k <= d; k++) begin
               @(posedge clk); #1;
               ir = instr;
               mem_rdy = (k == d);
               e = s.o;
               if (k == d && s.kind == K_RD) e.mdr_in = 1'b1;
               @(negedge clk);
               a = sample();
               checks++;
               if (a !== e) begin
                  failures++;
                  $display("FAIL %s op=%h wait cycle %0d: got %h expected %h", tag, instr[31:27], n, a, e);
               end
               if (a.read === 1'b1) rd_seen++;
               n++;
            end
         end
      end
   endtask

   task automatic check_halted(input bit ill, input bit tmo, input string tag);
      outs_t e, a;
      e = '0;
      e.illegal = ill;
      e.timeout = tmo;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         mem_rdy = 1'($urandom_range(0, 1));
         @(negedge clk);
         a = sample();
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL %s halt cycle %0d: got %h expected %h", tag, k, a, e);
         end
      end
   endtask

   // One-cycle clr from wherever the sequencer is; the following cycle is RST.
   task automatic apply_clr(input string tag);
      outs_t a;
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      a = sample();
      checks++;
      if (a !== idle()) begin
         failures++;
         $display("FAIL %s rst cycle: got %h expected %h", tag, a, idle());
      end
   endtask

   task automatic test_reset();
      outs_t a;
      clr = 1'b1;
      mem_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = sample();
      checks++;
      if (a !== idle()) begin
         failures++;
         $display("FAIL reset_held: got %h expected %h", a, idle());
      end
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      a = sample();
      checks++;
      if (a !== idle()) begin
         failures++;
         $display("FAIL reset_rst_cycle: got %h expected %h", a, idle());
      end
   endtask

   task automatic test_fetch();
      run_instr({5'h1A, 27'($urandom)}, 0, 0, 1'b1, "fetch");
   endtask

   task automatic test_add();
      run_instr({5'h03, 4'd3, 4'd1, 4'd2, 15'($urandom)}, -1, -1, 1'b0, "add");
   endtask

   task automatic test_ld_delay();
      run_instr({5'h00, 4'd5, 4'd2, 4'd0, 15'd4}, -1, 3, 1'b0, "ld");
      checks++;
      if (rd_seen != 4) begin
         failures++;
         $display("FAIL ld_read_cycles: got %0d expected 4", rd_seen);
      end
   endtask

   task automatic test_mul_illegal();
      run_instr({5'h0F, 4'd4, 4'd6, 19'($urandom)}, -1, -1, 1'b0, "mul");
      run_instr({5'h1F, 27'($urandom)}, -1, -1, 1'b0, "illegal");
      check_halted(1'b1, 1'b0, "illegal");
      apply_clr("illegal_clr");
   endtask

   task automatic test_halt();
      run_instr({5'h1B, 27'($urandom)}, -1, -1, 1'b0, "halt");
      check_halted(1'b0, 1'b0, "halt");
      apply_clr("halt_clr");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         logic [4:0] op;
         if ($urandom_range(0, 7) == 0) begin
            op = stop_ops[$urandom_range(0, 9)];
            run_instr({op, 27'($urandom)}, -1, -1, 1'b0, "b2b_stop");
            check_halted(op != 5'h1B, 1'b0, "b2b_halted");
            apply_clr("b2b_clr");
         end else begin
            op = legal_ops[$urandom_range(0, 21)];
            run_instr({op, 27'($urandom)}, -1, -1, 1'b0, "b2b");
         end
      end
   endtask

   // Long fetch wait, then clr in the middle of it.
   task automatic test_wait_clr();
      outs_t e, a;
      int n;
`ifdef CU_MEM_TIMEOUT_EN
      n = 6;
`else
      n = 20;
`endif
      @(posedge clk); #1;
      ir = {5'h1A, 27'($urandom)};
      mem_rdy = 1'b0;
      @(negedge clk);
      e = idle(); e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1;
      a = sample();
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL wait_clr t0: got %h expected %h", a, e);
      end
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         mem_rdy = 1'b0;
         @(negedge clk);
         e = idle(); e.read = 1'b1;
         a = sample();
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL wait_clr wait %0d: got %h expected %h", k, a, e);
         end
      end
      apply_clr("wait_clr");
      run_instr({legal_ops[$urandom_range(0, 21)], 27'($urandom)}, -1, -1, 1'b0, "after_clr");
   endtask

`ifdef CU_MEM_TIMEOUT_EN
   task automatic test_timeout();
      outs_t e, a;
      @(posedge clk); #1;
      ir = {5'h1A, 27'($urandom)};
      mem_rdy = 1'b0;
      @(negedge clk);
      e = idle(); e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1;
      a = sample();
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL timeout t0: got %h expected %h", a, e);
      end
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         mem_rdy = 1'b0;
         @(negedge clk);
         e = idle(); e.read = 1'b1;
         a = sample();
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL timeout wait %0d: got %h expected %h", k, a, e);
         end
      end
      check_halted(1'b0, 1'b1, "timeout");
      apply_clr("timeout_clr");
   endtask
`endif

   initial begin
      test_reset();
      test_fetch();
      test_add();
      test_ld_delay();
      test_mul_illegal();
      test_halt();
      test_back_to_back();
      test_wait_clr();
`ifdef CU_MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clk  in  1  rising-edge clock, the sole clock.
REQ-002 clr  in  1  reset, synchronous, active-high.
REQ-003 ir  in  32  instruction register contents. Fields: op=[31:27], ra=[26:23], rb=[22:19], rc=[18:15].
REQ-004 mem_rdy  in  1  memory completion strobe for read/write.
REQ-005 rin, rout  out  16 each  one-hot register load/drive enables for R0..R15.
REQ-006 pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out  out  1 each  bus drive strobes.
REQ-007 pc_in, ir_in, mdr_in, mar_in, y_in, z_in, hi_in, lo_in, inc_pc  out  1 each  load strobes.
REQ-008 read, write  out  1 each  memory request strobes.
REQ-009 alu_op  out  5  ALU operation code.
REQ-010 run, illegal, timeout  out  1 each  status flags.

Function
REQ-011 Strobe outputs SHALL be Moore outputs decoded from the state register and ir; they carry no combinational path from mem_rdy except mdr_in in the wait states.
REQ-012 At most one bus-drive strobe (REQ-006, rout) SHALL be asserted per cycle, and rin/rout SHALL each be zero or one-hot.
REQ-013 States: RST, T0..T7, HALT; T0..T2 form the fetch, and T3..T7 execute by opcode class.
REQ-014 Fetch: T0 pc_out, mar_in, inc_pc; T1 read held until mem_rdy=1, with mdr_in asserted only in the mem_rdy cycle; T2 mdr_out, ir_in; then T3.
REQ-015 R-format (op 03..0B): T3 rout[rb], y_in; T4 rout[rc], alu_op=op, z_in; T5 zlow_out, rin[ra]; then T0.
REQ-016 Immediate (0C addi, 0D andi, 0E ori): as REQ-015, except T4 uses c_out and alu_op is 03, 05 or 06 respectively.
REQ-017 ldi (01): T3 rout[rb], y_in; T4 c_out, alu_op=03, z_in; T5 zlow_out, rin[ra].
REQ-018 ld (00): T3..T4 as ldi; T5 zlow_out, mar_in; T6 read wait as in T1; T7 mdr_out, rin[ra].
REQ-019 st (02): T3..T5 as ld; T6 rout[ra], mdr_in (read=0); T7 write held until mem_rdy=1; then T0.
REQ-020 mul/div (0F/10): T3 rout[ra], y_in; T4 rout[rb], alu_op=op, z_in; T5 zlow_out, lo_in; T6 zhigh_out, hi_in.
REQ-021 neg/not (11/12): T3 rout[rb], alu_op=op, z_in; T4 zlow_out, rin[ra].
REQ-022 mfhi/mflo (18/19): T3 hi_out or lo_out, rin[ra]; nop (1A): T3 then T0.
REQ-023 halt (1B): enter HALT with run=0; HALT exits only on clr.
REQ-024 Any other opcode SHALL enter HALT with illegal=1.
REQ-025 alu_op SHALL be 0 in every state where z_in=0.

Reset
REQ-026 clr SHALL force state RST next edge from any state, including mid-wait; outputs then all 0, run=1, illegal=0, timeout=0.
REQ-027 RST SHALL last exactly one cycle, then go to T0 unconditionally.

Configuration
REQ-028 With CU_MEM_TIMEOUT_EN defined, a 4-bit counter SHALL run in each read/write wait state; 16 cycles without mem_rdy SHALL enter HALT with timeout=1, and the counter clears on entering a wait state.
REQ-029 Without CU_MEM_TIMEOUT_EN, waits SHALL be unbounded and timeout SHALL be tied 0.

Structure
REQ-030 Package cu_pkg SHALL hold the state enum, opcode constants and ALU op constants.
REQ-031 Sub-module reg_decoder (4-bit index plus enable to 16-bit one-hot) SHALL be instantiated twice, for rin and rout.

Verification
REQ-032 clr for 2 cycles, then mem_rdy=1 constantly -> RST 1 cycle; T0 with pc_out=mar_in=inc_pc=1; read in T1; ir_in in T2.
REQ-033 ir=add R3,R1,R2 (op 03) -> T3 rout=0x0002; T4 rout=0x0004 with alu_op=03; T5 rin=0x0008; back to T0.
REQ-034 ld R5,4(R2) with mem_rdy delayed 3 cycles in T6 -> read high for 4 cycles; mdr_in only in the 4th; T7 rin=0x0020.
REQ-035 mul R4,R6 -> lo_in in T5 and hi_in in T6; op 1F -> HALT, illegal=1, run=0, all strobes 0.
REQ-036 With CU_MEM_TIMEOUT_EN, mem_rdy=0 in T1 -> HALT after 16 cycles with timeout=1; clr asserted mid-wait -> RST next cycle.
